memory_arbiter: RTL and testbench
=================================

MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: maximum number of bus cycles a transaction waits for bus_ready before it is aborted.
REQ-002 clock  input  1  system clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 if_read_enable  input  1  instruction fetch request.
REQ-005 if_read_address  input  32  fetch byte address.
REQ-006 if_read_data  output  32  fetched instruction.
REQ-007 if_stall_request  output  1  fetch is not complete this cycle.
REQ-008 mem_read_enable  input  1  data read request.
REQ-009 mem_read_address  input  32  data read address.
REQ-010 mem_read_data  output  32  data read result.
REQ-011 mem_write_enable  input  1  data write request.
REQ-012 mem_write_address  input  32  data write address.
REQ-013 mem_write_select  input  4  byte enables for the write.
REQ-014 mem_write_data  input  32  write data.
REQ-015 mem_stall_request  output  1  data access is not complete this cycle.
REQ-016 bus_request  output  1  a transaction is active on the shared memory bus.
REQ-017 bus_write  output  1  the active transaction is a write.
REQ-018 bus_address  output  32  transaction address.
REQ-019 bus_select  output  4  byte enables; 4'b1111 for every read.
REQ-020 bus_write_data  output  32  write data for the transaction.
REQ-021 bus_ready  input  1  the transaction completes this cycle.
REQ-022 bus_read_data  input  32  read data, valid only while bus_ready=1.
REQ-023 bus_error  output  1  sticky flag: a transaction has timed out.

Function
REQ-024 The FSM SHALL have the states IDLE, FETCH and DATA; all bus_* outputs SHALL be registered, with bus_request=1 exactly in FETCH and DATA.
REQ-025 In IDLE, a pending data request (read or write) and a pending fetch miss SHALL be granted per a priority bit: data first after reset or after a FETCH, fetch first after a DATA.
REQ-026 On a grant, the request's address, select, write data and kind SHALL be latched into the bus registers, and the FSM SHALL move to FETCH or DATA on the same edge.
REQ-027 mem_write_enable SHALL take precedence over mem_read_enable when both are high.
REQ-028 In FETCH or DATA with bus_ready=1, the transaction SHALL complete: return to IDLE next edge and drop bus_request; minimum access latency is 2 cycles, grant to IDLE.
REQ-029 In FETCH on completion, if_read_data=bus_read_data and if_stall_request=0 combinationally in that cycle.
REQ-030 In DATA on a read completion, mem_read_data=bus_read_data combinationally in that cycle; on a read or write completion, mem_stall_request=0 in that cycle.
REQ-031 Otherwise: if_stall_request=if_read_enable & ~fetch_hit; mem_stall_request=(mem_read_enable|mem_write_enable) & ~completion; mem_read_data=0; if_read_data=0 unless a hit.
REQ-032 The one-entry fetch buffer (valid, address[31:2], data) SHALL load on every FETCH completion.
REQ-033 fetch_hit = valid & if_read_enable & (if_read_address[31:2]==buffer address); on a hit, if_read_data=buffer data, no stall, no bus access, and not a pending fetch for arbitration.
REQ-034 The buffer SHALL be invalidated on completion of a DATA write whose address[31:2] matches, and on any timeout of a FETCH.
REQ-035 Requests withdrawn mid-transaction SHALL NOT abort the bus transaction; its result SHALL be discarded, except that a completed fetch still loads the buffer.
REQ-036 The wait counter SHALL clear on grant and increment each cycle in FETCH or DATA without bus_ready.
REQ-037 When the counter reaches TIMEOUT_CYCLES, the transaction SHALL complete as if ready with read data 0, and bus_error SHALL be set until reset.
REQ-038 Simultaneous bus_ready and timeout SHALL be treated as a normal completion, with bus_error unchanged.

Reset
REQ-039 reset=0 SHALL asynchronously force state IDLE, the bus_* outputs, buffer valid, counter and bus_error to 0, and the priority bit to data-first.
REQ-040 If reset is asserted mid-transaction, the transaction SHALL be abandoned with no buffer update.
REQ-041 The combinational outputs SHALL reflect the reset state (stalls follow the requests).

Verification
REQ-042 Fetch at 0x100, bus_ready 3 cycles after grant -> if_stall_request high for 4 cycles, then if_read_data=bus_read_data; the next-cycle repeat fetch of 0x100 hits with no bus_request.
REQ-043 Data read at 0x200 and fetch at 0x104 in the same IDLE cycle, bus_ready immediate -> DATA is granted first and FETCH next; the then-pending data request waits one FETCH.
REQ-044 Fetch 0x100 buffered, then a write to 0x102 with select 4'b0100 -> bus_write=1, bus_select=4'b0100; the subsequent fetch of 0x100 misses.
REQ-045 bus_ready never asserted, TIMEOUT_CYCLES=4 -> completion after 4 wait cycles with mem_read_data=0; bus_error=1 held until reset.
REQ-046 reset=0 pulse mid-DATA -> bus_request=0 immediately; state IDLE; bus_error=0; buffer invalid.

Source files
------------

// File: rtl/memory_arbiter.sv
// memory_arbiter
// Shares one memory bus between an instruction-fetch port and a data
// read/write port. A one-entry fetch buffer answers repeated fetches of the
// same word without a bus access. A wait counter aborts a transaction that
// never sees bus_ready and raises a sticky bus_error.
//
// Ports
//   clock, reset                system clock, asynchronous active-low reset
//   if_read_*                   fetch request / result / stall
//   mem_read_*, mem_write_*     data read and write requests / result / stall
//   bus_request .. bus_write_data   registered bus transaction outputs
//   bus_ready, bus_read_data    bus completion and read data
//   bus_error                   sticky timeout flag
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no bus transaction; arbitrate pending data / fetch requests
// FETCH | instruction fetch on the bus, waiting for bus_ready
// DATA  | data read or write on the bus, waiting for bus_ready
module memory_arbiter #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        if_read_enable,
   input  logic [31:0] if_read_address,
   output logic [31:0] if_read_data,
   output logic        if_stall_request,
   input  logic        mem_read_enable,
   input  logic [31:0] mem_read_address,
   output logic [31:0] mem_read_data,
   input  logic        mem_write_enable,
   input  logic [31:0] mem_write_address,
   input  logic [3:0]  mem_write_select,
   input  logic [31:0] mem_write_data,
   output logic        mem_stall_request,
   output logic        bus_request,
   output logic        bus_write,
   output logic [31:0] bus_address,
   output logic [3:0]  bus_select,
   output logic [31:0] bus_write_data,
   input  logic        bus_ready,
   input  logic [31:0] bus_read_data,
   output logic        bus_error
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DATA  = 2'd2
   } state_t;

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  wait_cnt;
   logic              prio_fetch;
   logic              buf_valid;
   logic [29:0]       buf_addr;
   logic [31:0]       buf_data;

   logic              fetch_hit;
   logic              fetch_pending;
   logic              data_pending;
   logic              timeout;
   logic              xfer_done;
   logic              fetch_done;
   logic              data_done;
   logic [31:0]       rdata;
   logic              grant_fetch;
   logic              grant_data;

   assign fetch_hit     = buf_valid & if_read_enable & (if_read_address[31:2] == buf_addr);
   assign fetch_pending = if_read_enable & ~fetch_hit;
   assign data_pending  = mem_read_enable | mem_write_enable;
   assign timeout       = (wait_cnt == CNT_MAX);
   // bus_ready wins over a coincident timeout, so the transfer ends normally.
   assign xfer_done     = (state != IDLE) & (bus_ready | timeout);
   assign fetch_done    = (state == FETCH) & xfer_done;
   assign data_done     = (state == DATA) & xfer_done;
   assign rdata         = bus_ready ? bus_read_data : 32'h0;

   always_comb begin
      state_nxt   = state;
      grant_fetch = 1'b0;
      grant_data  = 1'b0;
      case (state)
         IDLE: begin
            if (data_pending && (!fetch_pending || !prio_fetch)) begin
               state_nxt  = DATA;
               grant_data = 1'b1;
            end else if (fetch_pending) begin
               state_nxt   = FETCH;
               grant_fetch = 1'b1;
            end
         end
         FETCH, DATA: begin
            if (xfer_done) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign if_read_data      = fetch_done ? rdata : (fetch_hit ? buf_data : 32'h0);
   assign if_stall_request  = if_read_enable & ~fetch_hit & ~fetch_done;
   assign mem_read_data     = (data_done & ~bus_write) ? rdata : 32'h0;
   assign mem_stall_request = data_pending & ~data_done;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         bus_request    <= 1'b0;
         bus_write      <= 1'b0;
         bus_address    <= 32'h0;
         bus_select     <= 4'h0;
         bus_write_data <= 32'h0;
         bus_error      <= 1'b0;
         wait_cnt       <= '0;
         prio_fetch     <= 1'b0;
         buf_valid      <= 1'b0;
         buf_addr       <= 30'h0;
         buf_data       <= 32'h0;
      end else begin
         if (grant_fetch) begin
            bus_request    <= 1'b1;
            bus_write      <= 1'b0;
            bus_address    <= if_read_address;
            bus_select     <= 4'hF;
            bus_write_data <= 32'h0;
            wait_cnt       <= '0;
         end else if (grant_data) begin
            // a write beats a simultaneous read
            bus_request    <= 1'b1;
            bus_write      <= mem_write_enable;
            bus_address    <= mem_write_enable ? mem_write_address : mem_read_address;
            bus_select     <= mem_write_enable ? mem_write_select : 4'hF;
            bus_write_data <= mem_write_enable ? mem_write_data : 32'h0;
            wait_cnt       <= '0;
         end else if (xfer_done) begin
            bus_request <= 1'b0;
            bus_write   <= 1'b0;
         end else if (state != IDLE) begin
            wait_cnt <= wait_cnt + CNT_ONE;
         end

         if (xfer_done && !bus_ready) bus_error <= 1'b1;

         if (fetch_done)     prio_fetch <= 1'b0;
         else if (data_done) prio_fetch <= 1'b1;

         // A completed fetch refills the buffer even if the requester has
         // moved on; an aborted fetch or an overlapping write kills it.
         if (fetch_done) begin
            if (bus_ready) begin
               buf_valid <= 1'b1;
               buf_addr  <= bus_address[31:2];
               buf_data  <= bus_read_data;
            end else begin
               buf_valid <= 1'b0;
            end
         end else if (data_done && bus_write && (bus_address[31:2] == buf_addr)) begin
            buf_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter with a short timeout; expected values go
// into a scoreboard queue as stimulus is applied and are popped as outputs appear.
module tb_memory_arbiter;

   localparam int TIMEOUT = 4;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        if_read_enable;
   logic [31:0] if_read_address;
   logic [31:0] if_read_data;
   logic        if_stall_request;
   logic        mem_read_enable;
   logic [31:0] mem_read_address;
   logic [31:0] mem_read_data;
   logic        mem_write_enable;
   logic [31:0] mem_write_address;
   logic [3:0]  mem_write_select;
   logic [31:0] mem_write_data;
   logic        mem_stall_request;
   logic        bus_request;
   logic        bus_write;
   logic [31:0] bus_address;
   logic [3:0]  bus_select;
   logic [31:0] bus_write_data;
   logic        bus_ready;
   logic [31:0] bus_read_data;
   logic        bus_error;

   memory_arbiter #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
      .clock             (clock),
      .reset             (reset),
      .if_read_enable    (if_read_enable),
      .if_read_address   (if_read_address),
      .if_read_data      (if_read_data),
      .if_stall_request  (if_stall_request),
      .mem_read_enable   (mem_read_enable),
      .mem_read_address  (mem_read_address),
      .mem_read_data     (mem_read_data),
      .mem_write_enable  (mem_write_enable),
      .mem_write_address (mem_write_address),
      .mem_write_select  (mem_write_select),
      .mem_write_data    (mem_write_data),
      .mem_stall_request (mem_stall_request),
      .bus_request       (bus_request),
      .bus_write         (bus_write),
      .bus_address       (bus_address),
      .bus_select        (bus_select),
      .bus_write_data    (bus_write_data),
      .bus_ready         (bus_ready),
      .bus_read_data     (bus_read_data),
      .bus_error         (bus_error)
   );

   always #5 clock = ~clock;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } sb_item_t;

   sb_item_t    sb_q[$];
   int          checks = 0;
   int          passed = 0;

   int          t_stalls;
   logic        t_done;
   logic [31:0] t_data;
   logic [31:0] t_addr;
   logic [3:0]  t_sel;
   logic        t_wr;
   logic [31:0] t_wdata;

   task automatic expect_val(input string tag, input logic [31:0] v);
      sb_q.push_back('{tag, v});
   endtask

   task automatic check(input logic [31:0] obs);
      sb_item_t e;
      checks++;
      if (sb_q.size() == 0) begin
         $error("FAIL scoreboard_empty: observed %0h, nothing expected", obs);
      end else begin
         e = sb_q.pop_front();
         assert (obs === e.val) passed++;
         else $error("FAIL %s: observed %0h, expected %0h", e.tag, obs, e.val);
      end
   endtask

   task automatic nxt();
      @(posedge clock);
      #1;
   endtask

   task automatic mid();
      @(negedge clock);
   endtask

   task automatic idle_inputs();
      if_read_enable   = 1'b0;
      mem_read_enable  = 1'b0;
      mem_write_enable = 1'b0;
      bus_ready        = 1'b0;
   endtask

   // Runs one transaction from the IDLE grant cycle to completion; bus_ready
   // rises after ready_at busy bus cycles. Returns with the DUT back in IDLE.
   task automatic run_bus(input logic is_fetch, input int ready_at, input logic [31:0] rd);
      int busy = 0;
      t_stalls = 0; t_done = 1'b0; t_data = 32'h0; t_addr = 32'h0;
      t_sel = 4'h0; t_wr = 1'b0; t_wdata = 32'h0;
      for (int i = 0; i < 16 && !t_done; i++) begin
         bus_ready     = bus_request && (busy == ready_at);
         bus_read_data = bus_ready ? rd : 32'hDEAD_BEEF;
         mid();
         if (bus_request && busy == 0) begin
            t_addr  = bus_address;
            t_sel   = bus_select;
            t_wr    = bus_write;
            t_wdata = bus_write_data;
         end
         if ((is_fetch ? if_stall_request : mem_stall_request) === 1'b1) begin
            t_stalls++;
         end else begin
            t_done = 1'b1;
            t_data = is_fetch ? if_read_data : mem_read_data;
         end
         if (bus_request) busy++;
         nxt();
      end
      bus_ready = 1'b0;
   endtask

   task automatic expect_txn(input string p, input int stalls, input logic [31:0] data,
                             input logic [31:0] addr, input logic [3:0] sel, input logic wr);
      expect_val({p, "_stall_cycles"}, 32'(stalls));
      expect_val({p, "_completed"}, 32'd1);
      expect_val({p, "_read_data"}, data);
      expect_val({p, "_bus_address"}, addr);
      expect_val({p, "_bus_select"}, 32'(sel));
      expect_val({p, "_bus_write"}, 32'(wr));
   endtask

   task automatic check_txn();
      check(32'(t_stalls));
      check(32'(t_done));
      check(t_data);
      check(t_addr);
      check(32'(t_sel));
      check(32'(t_wr));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      if_read_enable = 1'b0; if_read_address = 32'h0;
      mem_read_enable = 1'b0; mem_read_address = 32'h0;
      mem_write_enable = 1'b0; mem_write_address = 32'h0;
      mem_write_select = 4'h0; mem_write_data = 32'h0;
      bus_ready = 1'b0; bus_read_data = 32'h0;

      // reset state; combinational stalls follow requests during reset
      #1 reset = 1'b0;
      if_read_enable = 1'b1; if_read_address = 32'h100; mem_write_enable = 1'b1;
      expect_val("rst_bus_request", 32'd0);
      expect_val("rst_bus_error", 32'd0);
      expect_val("rst_if_stall", 32'd1);
      expect_val("rst_mem_stall", 32'd1);
      expect_val("rst_if_read_data", 32'd0);
      #1;
      check(32'(bus_request)); check(32'(bus_error));
      check(32'(if_stall_request)); check(32'(mem_stall_request)); check(if_read_data);
      idle_inputs();
      nxt(); nxt();
      reset = 1'b1;
      nxt();

      // fetch miss at 0x100, ready on the 4th bus cycle, then a buffer hit
      if_read_enable = 1'b1; if_read_address = 32'h100;
      expect_txn("fetch_miss", 4, 32'hA5A5_0100, 32'h100, 4'hF, 1'b0);
      run_bus(1'b1, 3, 32'hA5A5_0100);
      check_txn();
      expect_val("hit_if_stall", 32'd0);
      expect_val("hit_if_read_data", 32'hA5A5_0100);
      expect_val("hit_no_bus_request", 32'd0);
      mid(); check(32'(if_stall_request)); check(if_read_data);
      nxt(); mid(); check(32'(bus_request));
      nxt(); idle_inputs();

      // simultaneous data read 0x200 and fetch 0x104: data first, then fetch
      mem_read_enable = 1'b1; mem_read_address = 32'h200;
      if_read_enable = 1'b1; if_read_address = 32'h104;
      bus_ready = 1'b1; bus_read_data = 32'h2222_0200;
      expect_val("arb_idle_bus_request", 32'd0);
      expect_val("arb_first_address", 32'h200);
      expect_val("arb_first_mem_data", 32'h2222_0200);
      expect_val("arb_first_mem_stall", 32'd0);
      expect_val("arb_first_if_stall", 32'd1);
      mid(); check(32'(bus_request)); nxt();
      mid(); check(bus_address); check(mem_read_data);
      check(32'(mem_stall_request)); check(32'(if_stall_request));
      nxt();
      mem_read_address = 32'h204; bus_read_data = 32'h1111_0104;
      expect_val("arb_between_bus_request", 32'd0);
      expect_val("arb_second_address", 32'h104);
      expect_val("arb_second_if_data", 32'h1111_0104);
      expect_val("arb_second_if_stall", 32'd0);
      expect_val("arb_second_mem_stall", 32'd1);
      mid(); check(32'(bus_request)); nxt();
      mid(); check(bus_address); check(if_read_data);
      check(32'(if_stall_request)); check(32'(mem_stall_request));
      nxt();
      if_read_enable = 1'b0; bus_read_data = 32'h2222_0204;
      expect_val("arb_third_address", 32'h204);
      expect_val("arb_third_mem_data", 32'h2222_0204);
      nxt(); mid(); check(bus_address); check(mem_read_data);
      nxt(); idle_inputs();

      // buffer 0x100, then byte write to 0x102 (with a competing read)
      if_read_enable = 1'b1; if_read_address = 32'h100;
      expect_txn("refetch", 1, 32'h5555_0100, 32'h100, 4'hF, 1'b0);
      run_bus(1'b1, 0, 32'h5555_0100);
      check_txn();
      idle_inputs();
      mem_write_enable = 1'b1; mem_write_address = 32'h102;
      mem_write_select = 4'b0100; mem_write_data = 32'h00AB_0000;
      mem_read_enable = 1'b1; mem_read_address = 32'h300;
      expect_txn("write", 1, 32'h0, 32'h102, 4'b0100, 1'b1);
      expect_val("write_bus_write_data", 32'h00AB_0000);
      run_bus(1'b0, 0, 32'h0);
      check_txn(); check(t_wdata);
      idle_inputs();
      if_read_enable = 1'b1; if_read_address = 32'h100;
      expect_val("post_write_fetch_miss_stall", 32'd1);
      expect_val("post_write_fetch_bus_request", 32'd1);
      expect_val("post_write_fetch_data", 32'h6666_0100);
      mid(); check(32'(if_stall_request));
      nxt();
      bus_ready = 1'b1; bus_read_data = 32'h6666_0100;
      mid(); check(32'(bus_request)); check(if_read_data);
      nxt(); idle_inputs();

      // bus_ready arriving on the same cycle as the timeout is a normal completion
      mem_read_enable = 1'b1; mem_read_address = 32'h300;
      expect_txn("ready_at_limit", 5, 32'h3333_0300, 32'h300, 4'hF, 1'b0);
      expect_val("ready_at_limit_bus_error", 32'd0);
      run_bus(1'b0, TIMEOUT, 32'h3333_0300);
      check_txn();
      idle_inputs();
      mid(); check(32'(bus_error));
      nxt();

      // bus_ready never comes: abort after the wait limit, read data 0, sticky error
      mem_read_enable = 1'b1; mem_read_address = 32'h304;
      expect_txn("timeout", 5, 32'h0, 32'h304, 4'hF, 1'b0);
      expect_val("timeout_bus_error", 32'd1);
      expect_val("timeout_bus_request_dropped", 32'd0);
      expect_val("timeout_bus_error_held", 32'd1);
      run_bus(1'b0, 99, 32'h4444_0304);
      check_txn();
      idle_inputs();
      mid(); check(32'(bus_error)); check(32'(bus_request));
      nxt(); nxt(); nxt();
      mid(); check(32'(bus_error));
      nxt();

      // reset pulse in the middle of a DATA transaction
      mem_read_enable = 1'b1; mem_read_address = 32'h400;
      expect_val("pre_reset_bus_request", 32'd1);
      expect_val("in_reset_bus_request", 32'd0);
      expect_val("in_reset_bus_error", 32'd0);
      expect_val("in_reset_if_stall", 32'd1);
      expect_val("in_reset_mem_stall", 32'd1);
      nxt();
      mid(); check(32'(bus_request));
      #1 reset = 1'b0;
      #1 check(32'(bus_request)); check(32'(bus_error));
      if_read_enable = 1'b1; if_read_address = 32'h100;
      #1 check(32'(if_stall_request)); check(32'(mem_stall_request));
      mem_read_enable = 1'b0;
      @(posedge clock);
      #1 reset = 1'b1;
      expect_val("post_reset_fetch_bus_request", 32'd1);
      expect_val("post_reset_fetch_address", 32'h100);
      expect_val("post_reset_fetch_data", 32'h7777_0100);
      nxt();
      bus_ready = 1'b1; bus_read_data = 32'h7777_0100;
      mid(); check(32'(bus_request)); check(bus_address); check(if_read_data);
      nxt(); idle_inputs();
      nxt();

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
